// File: rtl/rom_fetch_pkg.sv
// Shared types and image/ROM geometry for the ROM fetch arbiter.
// A pixel fetch reads two consecutive bytes, so a valid start address leaves room for addr+1.
package rom_fetch_pkg;

    localparam int IMG_W      = 640;
    localparam int IMG_H      = 480;
    localparam int IMG_BYTES  = IMG_W * IMG_H;
    localparam int ROM_ADDR_W = 19;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_HI,
        ST_RD_LO,
        ST_CAP,
        ST_RESP
    } fetch_state_t;

    // Both addr and addr+1 must be at or below last_addr.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input logic [31:0] last_addr);
        return addr >= last_addr;
    endfunction

endpackage

// File: rtl/rom_fetch_arbiter_if.sv
// Request/response bundle between the pixel-fetch requesters and the arbiter.
// Lane i owns req_addr[i*ADDR_W +: ADDR_W]; rsp_data/rsp_err are shared and qualified by rsp_valid.
interface rom_fetch_arbiter_if
    import rom_fetch_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = ROM_ADDR_W
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [15:0]            rsp_data;
    logic                   rsp_err;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );

endinterface

// File: rtl/rom_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first requesting lane at or after ptr,
// wrapping around, and reports the grant both one-hot and as an index.
module rr_arbiter
    import rom_fetch_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    always_comb begin
        int  cand;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req[IDX_W'(cand)]) begin
                found                = 1'b1;
                gnt[IDX_W'(cand)]    = 1'b1;
                gnt_idx              = IDX_W'(cand);
            end
        end
        gnt_any = found;
    end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Shares the byte-wide image ROM read port among NREQ requesters, round-robin.
// Each accepted request becomes two byte reads assembled into a big-endian 16-bit word.
module rom_fetch_arbiter
    import rom_fetch_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int ADDR_W    = ROM_ADDR_W,
    parameter int LAST_ADDR = IMG_BYTES - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    rom_fetch_arbiter_if.slave bus,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_q,
    output logic              busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    fetch_state_t      state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  lane_q, lane_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        hi_q, hi_d;
    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              busy_q, busy_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [15:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic [NREQ-1:0]   gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_bad;
    logic [IDX_W-1:0]  next_ptr;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign gnt_addr = bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign gnt_bad  = addr_out_of_range(32'(gnt_addr), 32'(LAST_ADDR));
    assign next_ptr = (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    // The accept pulse is the only combinational output; it can only fire while idle.
    assign bus.req_ready = (state_q == ST_IDLE) ? gnt : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign rom_en        = rom_en_q;
    assign rom_addr      = rom_addr_q;
    assign busy          = busy_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lane_d      = lane_q;
        addr_d      = addr_q;
        hi_d        = hi_q;
        rom_addr_d  = rom_addr_q;
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    lane_d   = gnt_idx;
                    addr_d   = gnt_addr;
                    rr_ptr_d = next_ptr;
                    if (gnt_bad) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = gnt;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d    = ST_RD_HI;
                        rom_addr_d = gnt_addr;
                    end
                end
            end
            ST_RD_HI: begin
                state_d    = ST_RD_LO;
                rom_addr_d = addr_q + ADDR_W'(1);
            end
            ST_RD_LO: begin
                state_d = ST_CAP;
                hi_d    = rom_q;
            end
            // The low byte goes straight into the response register.
            ST_CAP: begin
                state_d             = ST_RESP;
                rsp_valid_d[lane_q] = 1'b1;
                rsp_data_d          = {hi_q, rom_q};
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered strobes are decoded from the state being entered.
        rom_en_d = (state_d == ST_RD_HI) || (state_d == ST_RD_LO);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            lane_q      <= '0;
            addr_q      <= '0;
            hi_q        <= '0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lane_q      <= lane_d;
            addr_q      <= addr_d;
            hi_q        <= hi_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Bench for rom_fetch_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-timeline reference model (grant cycle, fixed latencies, ROM contents).
module tb_rom_fetch_arbiter;
    import rom_fetch_pkg::*;

    localparam int NREQ      = 4;
    localparam int ADDR_W    = 19;
    localparam int LAST_ADDR = 307199;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_q = 8'h00;
    logic              busy;

    always #5 clk = ~clk;

    rom_fetch_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W)) bus();

    rom_fetch_arbiter #(
        .NREQ      (NREQ),
        .ADDR_W    (ADDR_W),
        .LAST_ADDR (LAST_ADDR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .busy     (busy)
    );

    // Synchronous ROM: data appears the cycle after the strobe.
    logic [7:0] rom_mem [0:524287];
    always @(posedge clk) if (rom_en) rom_q <= rom_mem[rom_addr];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Requester state
    bit                pend  [NREQ];
    logic [ADDR_W-1:0] paddr [NREQ];

    // Reference model: one outstanding transaction on a cycle timeline
    int                mptr = 0;
    int                free_at = 0;
    bit                have_txn = 0;
    int                t0 = 0;
    int                t_lane = 0;
    bit                t_err = 0;
    logic [ADDR_W-1:0] t_addr = '0;
    logic [ADDR_W-1:0] last_rom_addr = '0;
    int                granted = -1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic logic [ADDR_W-1:0] randAddr();
        case ($urandom_range(0, 9))
            0:       return ADDR_W'(LAST_ADDR);
            1:       return ADDR_W'(LAST_ADDR - 1);
            2:       return '0;
            3:       return ADDR_W'($urandom_range(LAST_ADDR + 1, 524287));
            default: return ADDR_W'($urandom_range(0, LAST_ADDR));
        endcase
    endfunction

    task automatic driveInputs();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i] = pend[i];
            bus.req_addr[i*ADDR_W +: ADDR_W] = pend[i] ? paddr[i] : ADDR_W'($urandom);
        end
    endtask

    // Called at the falling edge of cycle cyc: predicts and checks every output.
    task automatic modelCycle();
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] exp_valid;
        bit              exp_en;
        bit              exp_busy;
        int              rsp_at;
        logic [15:0]     exp_data;
        exp_ready = '0;
        exp_valid = '0;
        exp_en    = 1'b0;
        granted   = -1;
        if (have_txn) begin
            if (!t_err && cyc == t0 + 1) begin exp_en = 1'b1; last_rom_addr = t_addr; end
            if (!t_err && cyc == t0 + 2) begin exp_en = 1'b1; last_rom_addr = t_addr + 1'b1; end
            rsp_at = t0 + (t_err ? 1 : 4);
            if (cyc == rsp_at) begin
                exp_valid[t_lane] = 1'b1;
                exp_data = t_err ? 16'h0000 : {rom_mem[int'(t_addr)], rom_mem[int'(t_addr) + 1]};
                checkOutput("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
                checkOutput("rsp_err", 32'(bus.rsp_err), 32'(t_err));
            end
        end
        exp_busy = have_txn && (cyc > t0) && (cyc < free_at);
        checkOutput("rom_en", 32'(rom_en), 32'(exp_en));
        checkOutput("rom_addr", 32'(rom_addr), 32'(last_rom_addr));
        checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
        checkOutput("busy", 32'(busy), 32'(exp_busy));
        if (cyc >= free_at) begin
            for (int k = 0; k < NREQ; k++) begin
                int l;
                l = (mptr + k) % NREQ;
                if (granted < 0 && pend[l]) granted = l;
            end
            if (granted >= 0) begin
                exp_ready[granted] = 1'b1;
                have_txn = 1'b1;
                t0       = cyc;
                t_lane   = granted;
                t_addr   = paddr[granted];
                t_err    = (int'(paddr[granted]) + 1) > LAST_ADDR;
                free_at  = cyc + (t_err ? 2 : 5);
                mptr     = (granted + 1) % NREQ;
            end
        end
        checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    endtask

    task automatic applyStimulus(input int n, input int gen_pct, input int drop_pct, input logic [NREQ-1:0] hold_mask);
        repeat (n) begin
            driveInputs();
            @(negedge clk);
            modelCycle();
            @(posedge clk);
            #1;
            if (granted >= 0) begin
                pend[granted] = 1'b0;
                if (hold_mask[granted]) begin
                    pend[granted]  = 1'b1;
                    paddr[granted] = ADDR_W'($urandom_range(0, LAST_ADDR - 1));
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] && !hold_mask[i] && int'($urandom_range(0, 99)) < drop_pct) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && int'($urandom_range(0, 99)) < gen_pct) begin
                    pend[i]  = 1'b1;
                    paddr[i] = randAddr();
                end
            end
            cyc++;
        end
        driveInputs();
    endtask

    // Asynchronous reset, checked immediately, then released just after a rising edge.
    task automatic doReset();
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        driveInputs();
        rst_n = 1'b0;
        #1;
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("reset_rsp_data", 32'(bus.rsp_data), 32'h0);
        checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
        checkOutput("reset_rom_en", 32'(rom_en), 32'h0);
        checkOutput("reset_rom_addr", 32'(rom_addr), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("reset_hold_rsp_valid", 32'(bus.rsp_valid), 32'h0);
            checkOutput("reset_hold_rom_en", 32'(rom_en), 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        have_txn      = 1'b0;
        free_at       = cyc;
        mptr          = 0;
        last_rom_addr = '0;
    endtask

    initial begin
        for (int i = 0; i <= LAST_ADDR; i++) rom_mem[i] = 8'($urandom);
        rom_mem[100] = 8'hAB;
        rom_mem[101] = 8'hCD;
        rom_mem[0]   = 8'h12;
        rom_mem[1]   = 8'h34;
        for (int i = 0; i < NREQ; i++) begin
            pend[i]  = 1'b0;
            paddr[i] = '0;
        end
        bus.req_valid = '0;
        bus.req_addr  = '0;
        #2;
        doReset();

        $display("[TB] single lane fetch at 100");
        pend[0] = 1'b1; paddr[0] = 19'd100;
        applyStimulus(8, 0, 0, '0);

        $display("[TB] endpoint fetch at 0 on lane 2");
        pend[2] = 1'b1; paddr[2] = 19'd0;
        applyStimulus(8, 0, 0, '0);

        $display("[TB] range checks");
        pend[0] = 1'b1; paddr[0] = 19'd307199;
        pend[1] = 1'b1; paddr[1] = 19'd400000;
        pend[3] = 1'b1; paddr[3] = 19'd307198;
        applyStimulus(14, 0, 0, '0);

        $display("[TB] reset during second byte read");
        pend[1] = 1'b1; paddr[1] = 19'd500;
        applyStimulus(2, 0, 0, '0);
        doReset();

        $display("[TB] four-lane contention after reset");
        for (int i = 0; i < NREQ; i++) begin
            pend[i]  = 1'b1;
            paddr[i] = ADDR_W'(1000 + 37 * i);
        end
        applyStimulus(22, 0, 0, '0);

        $display("[TB] fairness between lanes 1 and 3");
        pend[1] = 1'b1; paddr[1] = 19'd2000;
        pend[3] = 1'b1; paddr[3] = 19'd3000;
        applyStimulus(25, 0, 0, 4'b1010);
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;

        $display("[TB] random traffic");
        applyStimulus(300, 30, 5, '0);
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        applyStimulus(8, 0, 0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
